// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: one-entry sample-pair buffer feeding a fixed-frame MSB-first serializer.
// Outputs are registered one cycle behind the counters; in_ready drops while the buffer holds a pair.
module i2s_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [SAMPLE_WIDTH-1:0] in_left_i,
  input  logic [SAMPLE_WIDTH-1:0] in_right_i,
  output logic                    bclk_o,
  output logic                    lrck_o,
  output logic                    sdata_o,
  output logic                    frame_start_o,
  output logic                    underrun_o
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int B_W        = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME_BITS - 1);
  localparam logic [B_W-1:0]   LR_FIRST = B_W'(SLOT_WIDTH - 1);
  localparam logic [B_W-1:0]   LR_LAST  = B_W'(FRAME_BITS - 2);

  logic [DIV_W-1:0]        div_q, div_d;
  logic [B_W-1:0]          b_q, b_d;
  logic                    buf_full_q, buf_full_d;
  logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d;
  logic [SAMPLE_WIDTH-1:0] buf_r_q, buf_r_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    bclk_q, bclk_d;
  logic                    lrck_q, lrck_d;
  logic                    sdata_q, sdata_d;
  logic                    fs_q, fs_d;
  logic                    ur_q, ur_d;

  logic                    accept;
  logic                    div_wrap;
  logic                    load;
  logic [FRAME_BITS-1:0]   buf_frame;

  // Frame image is indexed by bit period rather than shifted: bit b sits at FRAME_BITS-1-b.
  always_comb begin
    accept    = in_valid_i && !buf_full_q;
    div_wrap  = (div_q == DIV_LAST);
    load      = enable_i && div_wrap && (b_q == B_LAST);
    buf_frame = '0;
    buf_frame[FRAME_BITS-1 -: SAMPLE_WIDTH] = buf_l_q;
    buf_frame[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = buf_r_q;
  end

  always_comb begin
    div_d = '0;
    b_d   = B_LAST;
    if (enable_i) begin
      div_d = div_wrap ? '0 : div_q + DIV_W'(1);
      b_d   = b_q;
      if (div_wrap) begin
        b_d = (b_q == B_LAST) ? '0 : b_q + B_W'(1);
      end
    end
  end

  // An accept coinciding with a load lands in the buffer; the frame being loaded still sees it empty.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    if (load) begin
      buf_full_d = accept;
    end else if (accept) begin
      buf_full_d = 1'b1;
    end
    if (accept) begin
      buf_l_d = in_left_i;
      buf_r_d = in_right_i;
    end
  end

  always_comb begin
    frame_d = frame_q;
    if (!enable_i) begin
      frame_d = '0;
    end else if (load) begin
      frame_d = buf_full_q ? buf_frame : '0;
    end
  end

  always_comb begin
    bclk_d  = enable_i && (div_q >= DIV_HALF);
    lrck_d  = enable_i && (b_q >= LR_FIRST) && (b_q <= LR_LAST);
    sdata_d = enable_i && frame_q[B_LAST - b_q];
    fs_d    = enable_i && (b_q == '0) && (div_q == '0);
    ur_d    = load && !buf_full_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      b_q        <= B_LAST;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      frame_q    <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      fs_q       <= 1'b0;
      ur_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      b_q        <= b_d;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      frame_q    <= frame_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      fs_q       <= fs_d;
      ur_q       <= ur_d;
    end
  end

  assign in_ready_o    = !buf_full_q;
  assign bclk_o        = bclk_q;
  assign lrck_o        = lrck_q;
  assign sdata_o       = sdata_q;
  assign frame_start_o = fs_q;
  assign underrun_o    = ur_q;

endmodule
